// File: rtl/arty_btn_pkg.sv
// arty_btn_pkg
//   Shared types and default timing constants for the Arty push-button
//   conditioner (arty_btn_chan, arty_btn_debounce).
//   Contents:
//     arty_btn_rpt_state_e        - auto-repeat FSM state encoding
//     ARTY_BTN_DEBOUNCE_DFLT      - default debounce stable time (10 ms @ 25 MHz)
//     ARTY_BTN_REPEAT_DELAY_DFLT  - default held time before first repeat
//     ARTY_BTN_REPEAT_PERIOD_DFLT - default spacing of later repeats
//     arty_btn_cnt_w()            - counter width helper, never below 1 bit
package arty_btn_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE  = 2'd0,
    RPT_DELAY = 2'd1,
    RPT_RPT   = 2'd2
  } arty_btn_rpt_state_e;

  localparam int unsigned ARTY_BTN_DEBOUNCE_DFLT      = 250000;
  localparam int unsigned ARTY_BTN_REPEAT_DELAY_DFLT  = 12500000;
  localparam int unsigned ARTY_BTN_REPEAT_PERIOD_DFLT = 2500000;

  // Width needed to hold 0..n-1, with a 1-bit floor so tiny counts still
  // elaborate to a legal vector.
  function automatic int unsigned arty_btn_cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arty_btn_chan.sv
// arty_btn_chan
//   One push-button channel: 2-flop synchroniser, stable-time debounce
//   counter, registered level/press/release outputs and, when the macro
//   ARTY_BTN_REPEAT_EN is defined, an auto-repeat FSM.
//   Ports:
//     clk         in   system clock (clk_riscv)
//     rst         in   synchronous active-high reset
//     btn_i       in   raw asynchronous pad level, active-high
//     btn_o       out  debounced level (registered)
//     press_o     out  1-cycle pulse when btn_o rises
//     release_o   out  1-cycle pulse when btn_o falls
//     repeat_o    out  1-cycle auto-repeat pulse (0 without ARTY_BTN_REPEAT_EN)
//     rpt_state_o out  repeat FSM state, for observation (IDLE without repeat)
//   Handshake: none; all outputs are plain registered levels/pulses.
module arty_btn_chan
  import arty_btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = ARTY_BTN_DEBOUNCE_DFLT,
  parameter int unsigned REPEAT_DELAY    = ARTY_BTN_REPEAT_DELAY_DFLT,
  parameter int unsigned REPEAT_PERIOD   = ARTY_BTN_REPEAT_PERIOD_DFLT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_i,
  output logic                btn_o,
  output logic                press_o,
  output logic                release_o,
  output logic                repeat_o,
  output arty_btn_rpt_state_e rpt_state_o
);

  localparam int unsigned CNT_W = arty_btn_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             sync;
  logic             stable_q;
  logic [CNT_W-1:0] cnt_q;
  logic             press_evt;

  assign sync = sync_q[1];

  // stable_q is the accepted level; btn_o is a register stage behind it so
  // the level and its edge pulses leave the block together, one cycle after
  // the terminal-count accept.
  assign press_evt = stable_q & ~btn_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= 2'b00;
      stable_q  <= 1'b0;
      cnt_q     <= '0;
      btn_o     <= 1'b0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      if (sync == stable_q) begin
        // Any return to the accepted level restarts the stable-time window.
        cnt_q <= '0;
      end else if (cnt_q == CNT_TERM) begin
        stable_q <= sync;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      btn_o     <= stable_q;
      press_o   <= press_evt;
      release_o <= ~stable_q & btn_o;
    end
  end

`ifdef ARTY_BTN_REPEAT_EN
  localparam int unsigned RPT_MAX =
    (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W = arty_btn_cnt_w(RPT_MAX);
  localparam logic [RPT_W-1:0] DELAY_TERM  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_TERM = RPT_W'(REPEAT_PERIOD - 1);

  arty_btn_rpt_state_e state_q, state_d;
  logic [RPT_W-1:0]    rcnt_q, rcnt_d;
  logic                rpt_d;

  // The FSM keys off the same condition that raises press_o, so the counter
  // is 0 in the press_o cycle and the first repeat lands REPEAT_DELAY later.
  // A low accepted level forces IDLE with no pulse, which silences repeats
  // from the release_o cycle onwards.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    rpt_d   = 1'b0;
    if (press_evt) begin
      state_d = RPT_DELAY;
      rcnt_d  = '0;
    end else if (!stable_q) begin
      state_d = RPT_IDLE;
      rcnt_d  = '0;
    end else begin
      case (state_q)
        RPT_IDLE: begin
          rcnt_d = '0;
        end
        RPT_DELAY: begin
          if (rcnt_q == DELAY_TERM) begin
            state_d = RPT_RPT;
            rcnt_d  = '0;
            rpt_d   = 1'b1;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        RPT_RPT: begin
          if (rcnt_q == PERIOD_TERM) begin
            rcnt_d = '0;
            rpt_d  = 1'b1;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        default: begin
          state_d = RPT_IDLE;
          rcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RPT_IDLE;
      rcnt_q   <= '0;
      repeat_o <= 1'b0;
    end else begin
      state_q  <= state_d;
      rcnt_q   <= rcnt_d;
      repeat_o <= rpt_d;
    end
  end

  assign rpt_state_o = state_q;
`else
  // Repeat timing parameters have no effect in this build.
  logic unused_rpt_cfg;
  assign unused_rpt_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign repeat_o    = 1'b0;
  assign rpt_state_o = RPT_IDLE;
`endif

endmodule

// File: rtl/arty_btn_debounce.sv
// arty_btn_debounce
//   Conditions the raw BTN[3:0] pads for the push-button PIO input of the
//   system, in the clk_riscv domain. One arty_btn_chan per button plus a
//   sticky interrupt request that collects press (and repeat) events.
//   Optional feature: define ARTY_BTN_REPEAT_EN to build the auto-repeat
//   FSMs and let repeat_o feed irq_o; otherwise repeat_o is constant 0.
//   Ports:
//     clk        in   system clock (clk_riscv)
//     rst        in   synchronous active-high reset
//     btn_i      in   raw pad levels [NUM_BTN], active-high
//     btn_o      out  debounced levels (registered)
//     press_o    out  1-cycle pulse per accepted 0->1
//     release_o  out  1-cycle pulse per accepted 1->0
//     repeat_o   out  1-cycle auto-repeat pulses
//     irq_o      out  sticky interrupt request
//     irq_clr_i  in   clears irq_o; a simultaneous new event wins
module arty_btn_debounce
  import arty_btn_pkg::*;
#(
  parameter int unsigned NUM_BTN         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = ARTY_BTN_DEBOUNCE_DFLT,
  parameter int unsigned REPEAT_DELAY    = ARTY_BTN_REPEAT_DELAY_DFLT,
  parameter int unsigned REPEAT_PERIOD   = ARTY_BTN_REPEAT_PERIOD_DFLT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_i,
  output logic [NUM_BTN-1:0] btn_o,
  output logic [NUM_BTN-1:0] press_o,
  output logic [NUM_BTN-1:0] release_o,
  output logic [NUM_BTN-1:0] repeat_o,
  output logic               irq_o,
  input  logic               irq_clr_i
);

  // Per-channel repeat FSM states, kept as a probe point for checkers.
  arty_btn_rpt_state_e rpt_state_dbg_unused [NUM_BTN];

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    arty_btn_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .btn_i       (btn_i[i]),
      .btn_o       (btn_o[i]),
      .press_o     (press_o[i]),
      .release_o   (release_o[i]),
      .repeat_o    (repeat_o[i]),
      .rpt_state_o (rpt_state_dbg_unused[i])
    );
  end

  logic irq_set;

`ifdef ARTY_BTN_REPEAT_EN
  assign irq_set = (|press_o) | (|repeat_o);
`else
  assign irq_set = |press_o;
`endif

  // Set has priority over clear so an event arriving with the clear is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_o <= 1'b0;
    end else begin
      irq_o <= (irq_o & ~irq_clr_i) | irq_set;
    end
  end

endmodule

// File: tb/tb_arty_btn_debounce.sv
module tb_arty_btn_debounce;

  localparam int NB = 4;
  localparam int DC = 4;
  localparam int RD = 10;
  localparam int RP = 3;
`ifdef ARTY_BTN_REPEAT_EN
  localparam bit RPT_EN = 1'b1;
`else
  localparam bit RPT_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          irq_clr = 1'b0;
  logic [NB-1:0] btn = '0;
  logic [NB-1:0] btn_o, press_o, release_o, repeat_o;
  logic          irq_o;

  always #5 clk = ~clk;

  arty_btn_debounce #(
    .NUM_BTN         (NB),
    .DEBOUNCE_CYCLES (DC),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_i     (btn),
    .btn_o     (btn_o),
    .press_o   (press_o),
    .release_o (release_o),
    .repeat_o  (repeat_o),
    .irq_o     (irq_o),
    .irq_clr_i (irq_clr)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Level rule: a button's accepted level flips once the last DC synchronised
  // samples (pad value two edges late) all disagree with it; the visible
  // level and its edge pulses follow one edge later. Repeats are derived from
  // the elapsed time since the visible press while the visible level is high.
  logic [NB-1:0] m_stable = '0;
  logic [NB-1:0] m_btn    = '0;
  logic [NB-1:0] m_press  = '0;
  logic [NB-1:0] m_rel    = '0;
  logic [NB-1:0] m_rpt    = '0;
  logic          m_irq    = 1'b0;
  int            m_ptime [NB];
  bit            hist [NB][$];

  task automatic hist_reset();
    for (int ch = 0; ch < NB; ch++) begin
      hist[ch].delete();
      for (int i = 0; i < DC + 2; i++) hist[ch].push_back(1'b0);
    end
  endtask

  task automatic model_edge();
    logic [NB-1:0] nb, np, nr, nrp;
    logic          ni;
    int            d;
    bit            all_diff;
    if (rst) begin
      m_stable = '0; m_btn = '0; m_press = '0; m_rel = '0; m_rpt = '0;
      m_irq = 1'b0;
      hist_reset();
      return;
    end
    nb = m_stable;
    np = nb & ~m_btn;
    nr = ~nb & m_btn;
    ni = (m_irq & ~irq_clr) | (|m_press) | (RPT_EN & (|m_rpt));
    nrp = '0;
    for (int ch = 0; ch < NB; ch++) begin
      if (np[ch]) m_ptime[ch] = cyc;
      if (RPT_EN && nb[ch]) begin
        d = cyc - m_ptime[ch];
        if (d >= RD && ((d - RD) % RP) == 0) nrp[ch] = 1'b1;
      end
    end
    for (int ch = 0; ch < NB; ch++) begin
      hist[ch].push_back(btn[ch]);
      while (hist[ch].size() > DC + 2) void'(hist[ch].pop_front());
      all_diff = 1'b1;
      for (int j = 0; j < DC; j++)
        if (hist[ch][j] == m_stable[ch]) all_diff = 1'b0;
      if (all_diff) m_stable[ch] = ~m_stable[ch];
    end
    m_btn = nb; m_press = np; m_rel = nr; m_rpt = nrp; m_irq = ni;
  endtask

  task automatic check_all();
    chk("btn_o",     32'(btn_o),     32'(m_btn));
    chk("press_o",   32'(press_o),   32'(m_press));
    chk("release_o", 32'(release_o), 32'(m_rel));
    chk("repeat_o",  32'(repeat_o),  32'(m_rpt));
    chk("irq_o",     32'(irq_o),     32'(m_irq));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Wait (bounded) for any bit of the selected pulse output: 0=press 1=release.
  task automatic wait_pulse(input string tag, input int which);
    bit found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (which == 0 && press_o != '0)   found = 1'b1;
      if (which == 1 && release_o != '0) found = 1'b1;
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  int hold [NB];

  initial begin
    for (int ch = 0; ch < NB; ch++) begin m_ptime[ch] = 0; hold[ch] = 0; end
    hist_reset();

    // Reset state
    rst = 1'b1;
    ticks(3);
    chk("rst_btn", 32'(btn_o), 32'd0);
    chk("rst_irq", 32'(irq_o), 32'd0);
    rst = 1'b0;
    ticks(2);

    // Debounce latency: edge before edge 0, visible at edge DC+2
    btn[0] = 1'b1;
    ticks(6);
    chk("lat_early", 32'(btn_o[0]), 32'd0);
    tick();
    chk("lat_btn",   32'(btn_o[0]), 32'd1);
    chk("lat_press", 32'(press_o), 32'b0001);
    tick();
    chk("lat_irq",   32'(irq_o), 32'd1);

    // Glitch rejection (3-cycle pulse), then a real hold
    btn[1] = 1'b1;
    ticks(3);
    btn[1] = 1'b0;
    ticks(10);
    chk("glitch_btn", 32'(btn_o[1]), 32'd0);
    btn[1] = 1'b1;
    ticks(6);
    chk("hold_early",  32'(btn_o[1]), 32'd0);
    tick();
    chk("hold_accept", 32'(btn_o[1]), 32'd1);
    chk("hold_press",  32'(press_o[1]), 32'd1);

    // Concurrent channels + clear versus set
    btn[3:2] = 2'b11;
    wait_pulse("conc_press_seen", 0);
    chk("conc_press", 32'(press_o), 32'b1100);
    irq_clr = 1'b1;
    tick();
    chk("clr_vs_set", 32'(irq_o), 32'd1);
    tick();
    chk("clr_alone", 32'(irq_o), 32'd0);
    irq_clr = 1'b0;
    btn[3:2] = 2'b00;
    wait_pulse("conc_rel_seen", 1);
    chk("conc_release", 32'(release_o), 32'b1100);
    tick();
    chk("rel_no_irq", 32'(irq_o), 32'd0);

    // Repeat timing on channel 0 (expected silent when compiled out)
    btn[0] = 1'b0;
    ticks(10);
    btn[0] = 1'b1;
    wait_pulse("rpt_press_seen", 0);
    ticks(10);
    chk("rpt_first",  32'(repeat_o[0]), 32'(RPT_EN));
    ticks(3);
    chk("rpt_second", 32'(repeat_o[0]), 32'(RPT_EN));
    ticks(3);
    chk("rpt_third",  32'(repeat_o[0]), 32'(RPT_EN));
    btn[0] = 1'b0;
    wait_pulse("rpt_rel_seen", 1);
    ticks(12);
    chk("rpt_silent", 32'(repeat_o[0]), 32'd0);

    // Reset mid-count on channel 0
    btn[0] = 1'b1;
    ticks(4);
    rst = 1'b1;
    tick();
    chk("midrst_btn",   32'(btn_o), 32'd0);
    chk("midrst_press", 32'(press_o), 32'd0);
    rst = 1'b0;
    ticks(6);
    chk("midrst_early", 32'(btn_o[0]), 32'd0);
    tick();
    chk("midrst_accept", 32'(press_o[0]), 32'd1);

    // Randomised phase checked cycle by cycle against the model
    for (int n = 0; n < 3000; n++) begin
      for (int ch = 0; ch < NB; ch++) begin
        if (hold[ch] == 0) begin
          btn[ch]  = 1'($urandom_range(0, 1));
          hold[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                                 : int'($urandom_range(5, 30));
        end else begin
          hold[ch]--;
        end
      end
      irq_clr = ($urandom_range(0, 7) == 0);
      rst     = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 1'b0;
    irq_clr = 1'b0;
    ticks(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
